// File: rtl/aes128_enc_core.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Build option: define AES_ENC_ABORT_EN to add the abort input.
module aes128_enc_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    input  logic         ld,
    input  logic [127:0] text_in,
`ifdef AES_ENC_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy,
    output logic         done,
    output logic [127:0] text_out
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [2047:0] SboxTbl = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SboxTbl[8 * (255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        // RotWord then SubWord on the last word of the previous round key
        t  = {sbox(rk[23:16]) ^ rc, sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] st, input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) sb[i] = sbox(st[127 - 8 * i -: 8]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) sr[4 * c + r] = sb[4 * ((c + r) % 4) + r];
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4 * c];
            a1 = sr[4 * c + 1];
            a2 = sr[4 * c + 2];
            a3 = sr[4 * c + 3];
            if (last) begin
                res[127 - 32 * c -: 32] = {a0, a1, a2, a3};
            end else begin
                res[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                res[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                res[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                res[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        return res;
    endfunction

    state_e       state_q, state_d;
    logic [3:0]   round_q;
    logic [7:0]   rcon_q;
    logic [127:0] st_q, rk_q, key_q, text_out_q;
    logic         done_q;
    logic         start, halt, last;
    logic [127:0] k0, rk_next, round_out;

`ifdef AES_ENC_ABORT_EN
    assign halt = abort && (state_q == StRun);
`else
    assign halt = 1'b0;
`endif

    assign start     = ld && (state_q == StIdle);
    assign last      = (round_q == 4'd10);
    assign k0        = kld ? key : key_q;
    assign rk_next   = key_expand(rk_q, rcon_q);
    assign round_out = round_fn(st_q, last) ^ rk_next;

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StRun;
            StRun:  if (halt || last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q == StRun);
        done     = done_q;
        text_out = text_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q      <= '0;
            st_q       <= '0;
            rk_q       <= '0;
            rcon_q     <= '0;
            round_q    <= '0;
            text_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            if (kld && state_q == StIdle) key_q <= key;
            if (start) begin
                st_q    <= text_in ^ k0;
                rk_q    <= k0;
                round_q <= 4'd1;
                rcon_q  <= 8'h01;
            end else if (state_q == StRun && !halt) begin
                st_q    <= round_out;
                rk_q    <= rk_next;
                rcon_q  <= xtime(rcon_q);
                round_q <= last ? 4'd0 : round_q + 4'd1;
                if (last) text_out_q <= round_out;
            end else if (halt) begin
                round_q <= 4'd0;
            end
            done_q <= (state_q == StRun) && !halt && last;
        end
    end

endmodule

// File: tb/tb_aes128_enc_core.sv
// Self-checking bench for aes128_enc_core against a byte-array FIPS-197 model.
// Define AES_ENC_ABORT_EN to also exercise the abort input.
module tb_aes128_enc_core;

    logic         clk = 1'b0;
    logic         rst, kld, ld;
    logic [127:0] key, text_in;
    logic         busy, done;
    logic [127:0] text_out;
`ifdef AES_ENC_ABORT_EN
    logic         abort;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] sbox_m [256];

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_enc_core dut (
        .clk      (clk),
        .rst      (rst),
        .kld      (kld),
        .key      (key),
        .ld       (ld),
        .text_in  (text_in),
`ifdef AES_ENC_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .text_out (text_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map
    task automatic init_sbox();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] pt);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc, x;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) w[i] = k[127 - 8 * i -: 8];
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i - 4 + j];
            if (i % 16 == 0) begin
                x = tmp[0];
                tmp[0] = sbox_m[tmp[1]] ^ rc;
                tmp[1] = sbox_m[tmp[2]];
                tmp[2] = sbox_m[tmp[3]];
                tmp[3] = sbox_m[x];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i + j] = w[i - 16 + j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[4 * c + row] = s[4 * ((c + row) % 4) + row];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int row = 0; row < 4; row++) s[4 * c + row] = t[4 * c + row];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16 * r + i];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key = k; kld = 1'b1;
        cycle();
        kld = 1'b0;
    endtask

    task automatic start_block(input logic with_kld, input logic [127:0] k,
                               input logic [127:0] pt);
        key = k; text_in = pt; kld = with_kld; ld = 1'b1;
        cycle();
        kld = 1'b0; ld = 1'b0;
    endtask

    // Edges from now until done is seen, bounded at 40
    task automatic wait_done(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!done && n < 40);
    endtask

    task automatic test_reset();
        rst = 1'b1; kld = 1'b1; ld = 1'b1; key = K1; text_in = P1;
        cycle();
        cycle();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++;
        if (text_out !== 128'h0) begin
            errors++; $display("FAIL reset_text_out: got %h want 0", text_out);
        end
        rst = 1'b0; kld = 1'b0; ld = 1'b0;
        cycle();
    endtask

    task automatic test_kat_fips();
        int n;
        load_key(K1);
        start_block(1'b0, 128'h0, P1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL kat1_busy: got %b want 1", busy); end
        wait_done(n);
        checks++;
        if (n != 10) begin errors++; $display("FAIL kat1_latency: got %0d want 10", n); end
        checks++;
        if (text_out !== C1) begin errors++; $display("FAIL kat1_ct: got %h want %h", text_out, C1); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL kat1_idle: got %b want 0", busy); end
        cycle();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL kat1_pulse: got %b want 0", done); end
    endtask

    task automatic test_kld_with_ld();
        int n;
        start_block(1'b1, K2, P2);
        wait_done(n);
        checks++;
        if (n != 10) begin errors++; $display("FAIL kat2_latency: got %0d want 10", n); end
        checks++;
        if (text_out !== C2) begin errors++; $display("FAIL kat2_ct: got %h want %h", text_out, C2); end
    endtask

    task automatic test_back_to_back();
        int n;
        start_block(1'b1, 128'h0, 128'h0);
        wait_done(n);
        checks++;
        if (text_out !== C0) begin errors++; $display("FAIL b2b_first: got %h want %h", text_out, C0); end
        start_block(1'b0, 128'h0, 128'h0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", busy); end
        wait_done(n);
        checks++;
        if (n + 1 != 11) begin errors++; $display("FAIL b2b_spacing: got %0d want 11", n + 1); end
        checks++;
        if (text_out !== C0) begin errors++; $display("FAIL b2b_second: got %h want %h", text_out, C0); end
    endtask

    task automatic test_ignore_while_busy();
        int n;
        logic [127:0] pt;
        load_key(K1);
        start_block(1'b0, 128'h0, P1);
        cycle();
        cycle();
        key = 128'hdeadbeef_00000000_11111111_cafef00d; kld = 1'b1;
        cycle();
        kld = 1'b0;
        cycle();
        text_in = 128'hffeeddcc_bbaa9988_77665544_33221100; ld = 1'b1;
        cycle();
        ld = 1'b0;
        wait_done(n);
        checks++;
        if (n + 5 != 10) begin errors++; $display("FAIL ign_latency: got %0d want 10", n + 5); end
        checks++;
        if (text_out !== C1) begin errors++; $display("FAIL ign_ct: got %h want %h", text_out, C1); end
        pt = {$urandom, $urandom, $urandom, $urandom};
        start_block(1'b0, 128'h0, pt);
        wait_done(n);
        checks++;
        if (text_out !== aes_model(K1, pt)) begin
            errors++; $display("FAIL ign_keyreg: got %h want %h", text_out, aes_model(K1, pt));
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        logic [127:0] pt;
        load_key(K1);
        start_block(1'b0, 128'h0, P1);
        for (int i = 0; i < 5; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++;
        if (text_out !== 128'h0) begin
            errors++; $display("FAIL rstmid_text_out: got %h want 0", text_out);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) seen++;
            cycle();
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", seen); end
        pt = {$urandom, $urandom, $urandom, $urandom};
        start_block(1'b0, K1, pt);
        wait_done(n);
        checks++;
        if (text_out !== aes_model(128'h0, pt)) begin
            errors++; $display("FAIL rstmid_keyreg: got %h want %h", text_out, aes_model(128'h0, pt));
        end
    endtask

    task automatic test_random();
        int n;
        int gap;
        logic [127:0] k, pt, exp_ct;
        for (int t = 0; t < 8; t++) begin
            k  = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            exp_ct = aes_model(k, pt);
            if ($urandom_range(0, 1) == 0) begin
                load_key(k);
                gap = $urandom_range(0, 3);
                for (int i = 0; i < gap; i++) cycle();
                start_block(1'b0, ~k, pt);
            end else begin
                start_block(1'b1, k, pt);
            end
            wait_done(n);
            checks++;
            if (n != 10) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 10", t, n); end
            checks++;
            if (text_out !== exp_ct) begin
                errors++; $display("FAIL rand_ct[%0d]: got %h want %h", t, text_out, exp_ct);
            end
            text_in = ~pt;
            gap = $urandom_range(1, 4);
            for (int i = 0; i < gap; i++) cycle();
            checks++;
            if (text_out !== exp_ct || done !== 1'b0) begin
                errors++; $display("FAIL rand_hold[%0d]: got %h/%b want %h/0", t, text_out, done, exp_ct);
            end
        end
    endtask

`ifdef AES_ENC_ABORT_EN
    task automatic test_abort();
        int n;
        int seen;
        logic [127:0] prev, pt;
        load_key(K2);
        start_block(1'b0, 128'h0, P2);
        wait_done(n);
        prev = text_out;
        checks++;
        if (prev !== C2) begin errors++; $display("FAIL abort_pre: got %h want %h", prev, C2); end
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        checks++;
        if (text_out !== prev) begin errors++; $display("FAIL abort_idle: got %h want %h", text_out, prev); end
        pt = {$urandom, $urandom, $urandom, $urandom};
        start_block(1'b0, 128'h0, pt);
        for (int i = 0; i < 3; i++) cycle();
        abort = 1'b1; key = ~K2; kld = 1'b1;
        cycle();
        abort = 1'b0; kld = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++;
        if (text_out !== prev) begin errors++; $display("FAIL abort_hold: got %h want %h", text_out, prev); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) seen++;
            cycle();
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", seen); end
        abort = 1'b1;
        start_block(1'b0, 128'h0, pt);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_ld_wins: got %b want 1", busy); end
        wait_done(n);
        checks++;
        if (text_out !== aes_model(K2, pt)) begin
            errors++; $display("FAIL abort_after: got %h want %h", text_out, aes_model(K2, pt));
        end
    endtask
`endif

    initial begin
        rst = 1'b0; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;
`ifdef AES_ENC_ABORT_EN
        abort = 1'b0;
`endif
        init_sbox();
        test_reset();
        test_kat_fips();
        test_kld_with_ld();
        test_back_to_back();
        test_ignore_while_busy();
        test_reset_mid();
        test_random();
`ifdef AES_ENC_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
